muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Multi-cycle controller for the HI/LO multiply/divide path beside the main ALU. It accepts one mult/div/mthi/mtlo request at a time, runs a 32-step iterative shift-add multiply or restoring divide, and owns the architectural HI and LO registers. It drives `ready`/`busy` so the pipeline can stall HI/LO consumers, and it pulses `done` when a result commits.

## Interface
- `WIDTH`, default 32: operand width. Only 32 is verified. The step counter is sized to `$clog2(WIDTH)+1` bits.
- `clk` in, 1: single clock, rising edge.
- `reset` in, 1: asynchronous, active-high.
- `start` in, 1: request strobe, accepted when `start & ready` at a rising edge.
- `op` in, 2: 00 mult, 01 div, 10 mthi, 11 mtlo.
- `sign` in, 1: 1 signed, 0 unsigned. Ignored for mthi/mtlo.
- `abort` in, 1: kill the in-flight operation (exception flush).
- `A` in, WIDTH: multiplicand or dividend. Move source for mthi/mtlo.
- `B` in, WIDTH: multiplier or divisor.
- `ready` out, 1: high only in IDLE.
- `busy` out, 1: `~ready`.
- `done` out, 1: one-cycle pulse after HI/LO commit from mult or div.
- `div_by_zero` out, 1: valid with `done`; held until next accept.
- `outHI`, `outLO` out, WIDTH: architectural HI/LO registers.

## Operation
- States: IDLE, CALC, ADJ. Reset sets state IDLE, `outHI`=`outLO`=0, `done`=0, `div_by_zero`=0, counter 0.
- IDLE, mult/div accepted:
  - Register `|A|` and `|B|`; magnitudes are used only when `sign`=1.
  - Register the sign bits of A and B and the op.
  - Clear the 64-bit working register and counter.
  - Go to CALC.
- IDLE, mthi/mtlo accepted: write `A` into outHI (mthi) or outLO (mtlo) at that edge. State stays IDLE, no `done`, `ready` stays high.
- CALC, mult: each step, if multiplier LSB is 1, add multiplicand to the upper half. Shift the 64-bit {acc, multiplier} right by 1.
- CALC, div: each step, shift {rem, quot} left by 1 and trial-subtract divisor from rem. If no borrow, keep the difference and set the quotient LSB to 1.
- CALC ends after exactly 32 steps (counter 0..31), then go to ADJ.
- ADJ, signed result fix-up:
  - Product is negated (64-bit two's complement) when the operand signs differ.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the dividend's sign.
- ADJ commit: mult writes HI=product[63:32], LO=product[31:0]. Div writes HI=remainder, LO=quotient. Then go to IDLE with `done`=1 for one cycle.
- Divide by zero (B=0, div op):
  - Iterations still run the full 32 steps.
  - Commit forces LO=32'hFFFFFFFF and HI=A (raw dividend, unmodified).
  - `div_by_zero`=1.
- Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, `div_by_zero`=0. The result wraps with no flag.
- `abort` in CALC or ADJ: go to IDLE on the next edge. HI/LO unchanged, no `done`.
- `abort` in IDLE:
  - `start` is ignored on that edge, so abort wins.
  - This includes mthi/mtlo, which are not written.
- `start` while busy is ignored. The requester must hold `start` until it sees `ready`.

## Timing
- Accept edge E0. CALC occupies edges E1..E32. The ADJ commit is edge E33.
- `outHI`/`outLO` show the new result and `done`=1 in the cycle after E33, and `ready`=1 in that same cycle.
- A new request may be accepted at E34, giving a throughput of one op per 34 cycles.
- mthi/mtlo: 0 wait cycles. The value is visible in the cycle after E0.
- `done` is registered and clears on the following edge.
- `reset` asserted mid-operation:
  - Outputs clear immediately (asynchronously) and the state goes to IDLE.
  - The in-flight op is lost.
  - The first accept is allowed on the first rising edge after reset deasserts.

## Test plan
- Unsigned mult: A=0xFFFFFFFF, B=0xFFFFFFFF, sign=0. Expect HI=0xFFFFFFFE, LO=0x00000001, `done` exactly 34 cycles after the accept edge (E0+34), and `ready` low for E1..E33.
- Signed mult and div, sign=1:
  - A=-7 (0xFFFFFFF9), B=3, mult: HI=0xFFFFFFFF, LO=0xFFFFFFEB.
  - A=-7, B=3, div: LO=0xFFFFFFFE (-2), HI=0xFFFFFFFF (-1).
  - A=7, B=-3, div: LO=-2, HI=1.
- Divide by zero and overflow:
  - A=0x12345678, B=0, div: HI=0x12345678, LO=0xFFFFFFFF, `div_by_zero`=1.
  - A=0x80000000, B=0xFFFFFFFF, signed div: LO=0x80000000, HI=0, `div_by_zero`=0.
- Moves and busy rejection:
  - mthi A=0xCAFEF00D: outHI updates next cycle and `ready` never drops.
  - A second mult `start` issued at E5 is ignored.
  - HI/LO reflect only the first mult.
- Abort: preload HI=0x11, LO=0x22. Start a div and assert `abort` at E10. Expect IDLE at E11, HI/LO still 0x11/0x22, and no `done`. `start`+`abort` together in IDLE must also leave HI/LO unchanged.
- Reset mid-op: assert `reset` asynchronously at E20 of a mult. Outputs go to 0 without waiting for a clock edge. After deassert, a fresh mult 6×7 gives LO=42, HI=0.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: 32-step shift-add multiply / restoring divide controller owning HI/LO
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             sign,
    input  logic             abort,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] outHI,
    output logic [WIDTH-1:0] outLO
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, CALC, ADJ} stateT;
    stateT state, nextState;
    logic [CW-1:0] count;
    logic [2*WIDTH-1:0] work, product;
    logic [WIDTH-1:0] aMag, bMag, aRaw, aIn, bIn, quot, rem;
    logic aNeg, bNeg, isDiv, zeroDiv, accept, lastStep;
    logic [WIDTH:0] addSum, trial;
    assign ready = state == IDLE;
    assign busy = ~ready;
    assign accept = start & ready & ~abort;
    assign lastStep = count == CW'(WIDTH - 1);
    assign aIn = (sign & A[WIDTH-1]) ? -A : A;
    assign bIn = (sign & B[WIDTH-1]) ? -B : B;
    assign addSum = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, aMag} : '0);
    // remainder window includes the bit just shifted up, so it can exceed WIDTH bits
    assign trial = work[2*WIDTH-1:WIDTH-1] - {1'b0, bMag};
    assign product = (aNeg ^ bNeg) ? -work : work;
    assign quot = (aNeg ^ bNeg) ? -work[WIDTH-1:0] : work[WIDTH-1:0];
    assign rem = aNeg ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];
    always_comb begin
        nextState = state;
        nextState = abort ? IDLE :
                    (state == IDLE && accept && !op[1]) ? CALC :
                    (state == CALC && lastStep) ? ADJ :
                    (state == ADJ) ? IDLE : state;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= nextState;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            work <= '0;
            aMag <= '0;
            bMag <= '0;
            aRaw <= '0;
            aNeg <= 1'b0;
            bNeg <= 1'b0;
            isDiv <= 1'b0;
            zeroDiv <= 1'b0;
            done <= 1'b0;
            div_by_zero <= 1'b0;
            outHI <= '0;
            outLO <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                div_by_zero <= 1'b0;
                if (op == 2'b10) outHI <= A;
                else if (op == 2'b11) outLO <= A;
                else begin
                    aNeg <= sign & A[WIDTH-1];
                    bNeg <= sign & B[WIDTH-1];
                    aMag <= aIn;
                    bMag <= bIn;
                    aRaw <= A;
                    isDiv <= op[0];
                    zeroDiv <= B == '0;
                    work <= {{WIDTH{1'b0}}, op[0] ? aIn : bIn};
                    count <= '0;
                end
            end else if (state == CALC && !abort) begin
                count <= count + 1'b1;
                if (isDiv) work <= trial[WIDTH] ? {work[2*WIDTH-2:0], 1'b0}
                                                : {trial[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
                else work <= {addSum, work[WIDTH-1:1]};
            end else if (state == ADJ && !abort) begin
                done <= 1'b1;
                if (isDiv) begin
                    outHI <= zeroDiv ? aRaw : rem;
                    outLO <= zeroDiv ? '1 : quot;
                    div_by_zero <= zeroDiv;
                end else {outHI, outLO} <= product;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed and random checks of muldiv_sequencer against a cycle-level model
module tb_muldiv_sequencer;
    logic clk = 0, reset = 0, start = 0, sign = 0, abort = 0;
    logic [1:0] op = 0;
    logic [31:0] A = 0, B = 0;
    logic ready, busy, done, div_by_zero;
    logic [31:0] outHI, outLO;
    int compared = 0, mismatched = 0;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .sign(sign), .abort(abort),
        .A(A), .B(B), .ready(ready), .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .outHI(outHI), .outLO(outLO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // {div_by_zero, HI, LO} straight from the arithmetic definition
    function automatic logic [64:0] refOp(input logic [1:0] o, input logic s,
                                          input logic [31:0] a, input logic [31:0] b);
        longint p;
        logic [31:0] q, r;
        if (!o[0]) begin
            p = s ? longint'($signed(a)) * longint'($signed(b))
                  : longint'({32'b0, a}) * longint'({32'b0, b});
            return {1'b0, p[63:0]};
        end
        if (b == 0) return {1'b1, a, 32'hFFFFFFFF};
        if (s && a == 32'h80000000 && b == 32'hFFFFFFFF) return {1'b0, 32'h0, 32'h80000000};
        if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {1'b0, r, q};
    endfunction

    int left;
    logic [31:0] mHI, mLO;
    logic mDone, mDbz, armed = 0;
    logic [64:0] pend;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            left = 0; mHI = 0; mLO = 0; mDone = 0; mDbz = 0;
        end else begin
            mDone = 0;
            if (left != 0) begin
                if (abort) left = 0;
                else begin
                    left--;
                    if (left == 0) begin
                        {mDbz, mHI, mLO} = pend;
                        mDone = 1;
                    end
                end
            end else if (start && !abort) begin
                mDbz = 0;
                if (op == 2'b10) mHI = A;
                else if (op == 2'b11) mLO = A;
                else begin
                    pend = refOp(op, sign, A, B);
                    left = 33;
                end
            end
        end
    end

    always @(negedge clk)
        if (armed && !reset)
            chk("cycle", {ready, busy, done, div_by_zero, outHI, outLO},
                {left == 0, left != 0, mDone, mDbz, mHI, mLO});

    task automatic doOp(input logic [1:0] o, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input bit waitDone);
        int n = 0;
        while (!ready && n < 100) begin @(negedge clk); n++; end
        if (!ready) chk("ready_timeout", ready, 1);
        op = o; sign = s; A = a; B = b; start = 1;
        @(negedge clk);
        start = 0;
        if (waitDone && !o[1]) begin
            n = 1;
            while (!done && n < 60) begin @(negedge clk); n++; end
            chk("done_latency", n, 34);
        end
    endtask

    task automatic expectHL(input string name, input logic [31:0] hi, input logic [31:0] lo,
                            input logic dbz);
        chk(name, {div_by_zero, outHI, outLO}, {dbz, hi, lo});
    endtask

    initial begin
        #1 reset = 1;
        #2 chk("reset_state", {ready, busy, done, div_by_zero, outHI, outLO}, {4'b1000, 64'h0});
        @(negedge clk);
        reset = 0;
        armed = 1;
        doOp(0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
        expectHL("umult_max", 32'hFFFFFFFE, 32'h00000001, 0);
        doOp(0, 1, 32'hFFFFFFF9, 3, 1);
        expectHL("smult_neg7x3", 32'hFFFFFFFF, 32'hFFFFFFEB, 0);
        doOp(1, 1, 32'hFFFFFFF9, 3, 1);
        expectHL("sdiv_neg7by3", 32'hFFFFFFFF, 32'hFFFFFFFE, 0);
        doOp(1, 1, 7, 32'hFFFFFFFD, 1);
        expectHL("sdiv_7byneg3", 32'h1, 32'hFFFFFFFE, 0);
        doOp(1, 0, 32'h12345678, 0, 1);
        expectHL("div_by_zero", 32'h12345678, 32'hFFFFFFFF, 1);
        doOp(1, 1, 32'h80000000, 32'hFFFFFFFF, 1);
        expectHL("sdiv_overflow", 32'h0, 32'h80000000, 0);
        doOp(2, 0, 32'hCAFEF00D, 0, 1);
        chk("mthi_value", {ready, outHI}, {1'b1, 32'hCAFEF00D});
        doOp(0, 0, 1000, 77, 0);
        repeat (4) @(negedge clk);
        op = 0; A = 3; B = 3; start = 1;
        @(negedge clk);
        start = 0;
        while (!done && left != 0) @(negedge clk);
        expectHL("busy_reject", 32'h0, 32'd77000, 0);
        doOp(2, 0, 32'h11, 0, 1);
        doOp(3, 0, 32'h22, 0, 1);
        doOp(1, 0, 500, 7, 0);
        repeat (9) @(negedge clk);
        abort = 1;
        @(negedge clk);
        abort = 0;
        chk("abort_idle", ready, 1);
        repeat (40) begin
            @(negedge clk);
            if (done) chk("abort_no_done", done, 0);
        end
        expectHL("abort_keep", 32'h11, 32'h22, 0);
        op = 2; A = 32'hDEAD; start = 1; abort = 1;
        @(negedge clk);
        op = 0; A = 5; B = 5;
        @(negedge clk);
        start = 0; abort = 0;
        chk("start_abort_idle", {ready, outHI, outLO}, {1'b1, 32'h11, 32'h22});
        for (int i = 0; i < 60; i++) begin
            logic [1:0] o;
            logic [31:0] a, b;
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 0;
                1: b = 32'($urandom_range(1, 9));
                2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                default: ;
            endcase
            if ($urandom_range(0, 5) == 0) begin
                doOp(o, 1'($urandom), a, b, 0);
                repeat ($urandom_range(0, 34)) @(negedge clk);
                abort = 1;
                @(negedge clk);
                abort = 0;
            end else doOp(o, 1'($urandom), a, b, 1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        doOp(2, 0, 32'h55, 0, 1);
        doOp(0, 0, 5, 9, 0);
        repeat (19) @(negedge clk);
        #1 reset = 1;
        #1 chk("async_reset", {ready, done, div_by_zero, outHI, outLO}, {3'b100, 64'h0});
        @(negedge clk);
        reset = 0;
        doOp(0, 0, 6, 7, 1);
        expectHL("post_reset_mult", 32'h0, 32'd42, 0);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
